fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 128, meaning the filter length in taps; it is even and a power of two.
REQ-002 SHALL have parameter AW, default 7, meaning the sample-buffer address width, equal to log2(NTAPS).
REQ-003 SHALL have port clock  in  1  master clock, rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port din_enable  in  1  new-sample strobe, one cycle wide.
REQ-006 SHALL have port wr_en  out  1  write the current sample into the circular sample buffer.
REQ-007 SHALL have port wr_addr  out  AW  sample-buffer write address.
REQ-008 SHALL have port rd_addr  out  AW  sample-buffer read address for even tap 2k (datapath also reads rd_addr-1 for tap 2k+1).
REQ-009 SHALL have port coeffaddress  out  AW-1  coefficient-memory word address k (word k holds tap 2k in [17:0] and tap 2k+1 in [35:18]).
REQ-010 SHALL have port acc_clear  out  1  load the accumulators instead of adding to them.
REQ-011 SHALL have port acc_en  out  1  MAC-valid strobe to all 8 filter accumulators.
REQ-012 SHALL have port dout_latch  out  1  copy the accumulators to the dataout registers.
REQ-013 SHALL have port busy  out  1  a sample is being processed.
REQ-014 SHALL have port overrun  out  1  one-cycle pulse: a sample was dropped.
REQ-015 SHALL have port ovr_count  out  16  dropped-sample count.

Function
REQ-016 SHALL use FSM states IDLE, ADDR, DRAIN and LATCH; IDLE->ADDR on din_enable; ADDR->DRAIN after the address with k=NTAPS/2-1; DRAIN->LATCH after 1 cycle; LATCH->IDLE after 1 cycle.
REQ-017 SHALL, for din_enable sampled in IDLE at cycle T, assert wr_en with wr_addr=wptr at T+1, then increment wptr modulo NTAPS.
REQ-018 SHALL drive coeffaddress=k and rd_addr=(s-2k) mod NTAPS at T+1+k for k=0..NTAPS/2-1, where s is the wr_addr written at T+1.
REQ-019 SHALL assert acc_en at T+2..T+1+NTAPS/2, which is the address schedule delayed by the 1-cycle memory read latency.
REQ-020 SHALL assert acc_clear only at T+2, the first acc_en cycle.
REQ-021 SHALL pulse dout_latch at T+2+NTAPS/2 (T+66 for the default) and assert busy from T+1 to T+2+NTAPS/2 inclusive.
REQ-022 SHALL ignore din_enable asserted in any state other than IDLE, with these effects:
- no wr_en and no change to wptr;
- overrun pulses in the next cycle;
- the computation in flight continues unaffected.
REQ-023 SHALL accept a new din_enable in the first IDLE cycle after LATCH, giving a minimum sample period of NTAPS/2+3 cycles.
REQ-024 SHALL wrap rd_addr and wptr modulo NTAPS (e.g. s=1, k=1 gives rd_addr=NTAPS-1).
REQ-025 SHALL hold coeffaddress and rd_addr at 0 and all strobes low while in IDLE.

Reset
REQ-026 SHALL, on reset, set the state to IDLE and set wptr, wr_addr, rd_addr, coeffaddress, ovr_count and every strobe (wr_en, acc_clear, acc_en, dout_latch, busy, overrun) to 0.
REQ-027 SHALL, when reset is asserted mid-computation, abort with no further acc_en and no dout_latch; din_enable in the reset cycle is ignored and not counted.

Configuration
REQ-028 SHALL, with macro SEQ_OVERRUN_CNT_EN defined, increment ovr_count by 1 on each overrun pulse, saturating at 16'hFFFF.
REQ-029 SHALL, without SEQ_OVERRUN_CNT_EN, drive ovr_count constant 0; overrun pulses still occur.

Verification
REQ-030 SHALL cover single sample after reset: din_enable at T -> wr_en at T+1 with wr_addr=0; coeffaddress 0..63 at T+1..T+64; acc_clear at T+2 only; acc_en high for 64 cycles; dout_latch at T+66.
REQ-031 SHALL cover wrap-around: 130 samples at a period of 67 cycles -> wr_addr sequence ...,127,0,1; for the sample at wr_addr=1, rd_addr at k=1 is 127.
REQ-032 SHALL cover overrun: din_enable at T and at T+30 -> overrun at T+31, no second wr_en, dout_latch still at T+66; ovr_count=1 with the macro, 0 without.
REQ-033 SHALL cover back-to-back: din_enable at T and T+67 -> both accepted, no overrun; din_enable at T+66 -> dropped with overrun.
REQ-034 SHALL cover reset mid-run: reset at T+20 for 1 cycle -> acc_en low from T+21, no dout_latch, next sample written at wr_addr=0.
REQ-035 SHALL cover saturation (macro defined): force 65536 overruns -> ovr_count holds 16'hFFFF.

Source files
------------

// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample-strobe and memory/accumulator control bundle for the FIR MAC sequencer
//
// Purpose: groups the sequencer's handshake and control signals.
//   din_enable    new-sample strobe into the sequencer
//   wr_en/wr_addr sample-buffer write
//   rd_addr       sample-buffer read address (even tap)
//   coeffaddress  coefficient word address (two taps per word)
//   acc_clear     load instead of accumulate
//   acc_en        MAC-valid strobe
//   dout_latch    copy accumulators to output registers
//   busy          sample in progress
//   overrun       one-cycle dropped-sample pulse
//   ovr_count     dropped-sample count
// Modports: master = sequencer side, slave = datapath/source side.
interface fir_mac_sequencer_if #(
    parameter int AW = 7
);
    logic          din_enable;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-2:0] coeffaddress;
    logic          acc_clear;
    logic          acc_en;
    logic          dout_latch;
    logic          busy;
    logic          overrun;
    logic [15:0]   ovr_count;

    modport master (
        input  din_enable,
        output wr_en, wr_addr, rd_addr, coeffaddress, acc_clear, acc_en,
               dout_latch, busy, overrun, ovr_count
    );

    modport slave (
        output din_enable,
        input  wr_en, wr_addr, rd_addr, coeffaddress, acc_clear, acc_en,
               dout_latch, busy, overrun, ovr_count
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - address/strobe sequencer for a symmetric two-taps-per-cycle FIR MAC
//
// Purpose: on each accepted sample, writes it into the circular sample buffer
// and walks NTAPS/2 coefficient words, producing read addresses and delayed
// accumulator strobes, then latches the result.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - fir_mac_sequencer_if.master (all control/handshake signals)
// Optional feature: define SEQ_OVERRUN_CNT_EN to enable the saturating
// dropped-sample counter (ovr_count); otherwise ovr_count is tied to 0.
module fir_mac_sequencer #(
    parameter int NTAPS = 128,
    parameter int AW    = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    fir_mac_sequencer_if.master    bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    // NTAPS is a power of two, so the last word index NTAPS/2-1 is all ones.
    localparam logic [AW-2:0] K_LAST = {(AW-1){1'b1}};

    logic [1:0]    state_q, state_d;
    logic [AW-2:0] k_q, k_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] s_q, s_d;
    logic          wr_en_q, wr_en_d;
    logic          acc_en_q, acc_en_d;
    logic          acc_clear_q, acc_clear_d;
    logic          overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wptr_d    = wptr_q;
        s_d       = s_q;
        wr_en_d   = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.din_enable) begin
                    state_d = S_ADDR;
                    k_d     = '0;
                    s_d     = wptr_q;
                    wptr_d  = wptr_q + 1'b1;
                    wr_en_d = 1'b1;
                end
            end
            S_ADDR: begin
                overrun_d = bus.din_enable;
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                overrun_d = bus.din_enable;
                state_d   = S_LATCH;
            end
            S_LATCH: begin
                overrun_d = bus.din_enable;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulator strobes trail the address schedule by the memory read latency.
    assign acc_en_d    = (state_q == S_ADDR);
    assign acc_clear_d = (state_q == S_ADDR) && (k_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            wptr_q      <= '0;
            s_q         <= '0;
            wr_en_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_clear_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wptr_q      <= wptr_d;
            s_q         <= s_d;
            wr_en_q     <= wr_en_d;
            acc_en_q    <= acc_en_d;
            acc_clear_q <= acc_clear_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SEQ_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q;

    // Counts alongside the overrun pulse so the value is current while it is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovr_cnt_q <= '0;
        end else if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign bus.ovr_count = ovr_cnt_q;
`else
    assign bus.ovr_count = 16'd0;
`endif

    // Even tap 2k is s-2k; the AW-bit subtraction wraps modulo NTAPS.
    assign bus.rd_addr      = (state_q == S_ADDR) ? (s_q - {k_q, 1'b0}) : '0;
    assign bus.coeffaddress = (state_q == S_ADDR) ? k_q : '0;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = s_q;
    assign bus.acc_en       = acc_en_q;
    assign bus.acc_clear    = acc_clear_q;
    assign bus.dout_latch   = (state_q == S_LATCH);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
    localparam int NTAPS = 128;
    localparam int AW    = 7;
    localparam int HALF  = NTAPS / 2;

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   exp_wptr;
    int   exp_ovr;

    fir_mac_sequencer_if #(.AW(AW)) bus ();

    fir_mac_sequencer #(.NTAPS(NTAPS), .AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a sample in the current cycle (T) and checks cycles T+1..T+67.
    // extra > 0 pulses din_enable again at T+extra (expected to be dropped).
    // Returns in the IDLE cycle T+67 with din_enable low.
    task automatic run_sample(input int extra);
        int s;
        bit e_ovr;
        s = exp_wptr;
        exp_wptr = (exp_wptr + 1) % NTAPS;
        bus.din_enable = 1'b1;
        for (int c = 1; c <= HALF + 3; c++) begin
            tick();
            bus.din_enable = (c == extra);
            e_ovr = (extra > 0) && (c == extra + 1);
`ifdef SEQ_OVERRUN_CNT_EN
            if (e_ovr && exp_ovr < 16'hFFFF) exp_ovr++;
`endif
            check($sformatf("wr_en s%0d c%0d", s, c), 32'(bus.wr_en), 32'(c == 1));
            if (c == 1) check($sformatf("wr_addr s%0d", s), 32'(bus.wr_addr), 32'(s));
            check($sformatf("coeff s%0d c%0d", s, c), 32'(bus.coeffaddress),
                  (c <= HALF) ? 32'(c - 1) : 32'd0);
            check($sformatf("rd s%0d c%0d", s, c), 32'(bus.rd_addr),
                  (c <= HALF) ? 32'((s - 2 * (c - 1)) & (NTAPS - 1)) : 32'd0);
            check($sformatf("acc_en s%0d c%0d", s, c), 32'(bus.acc_en),
                  32'(c >= 2 && c <= HALF + 1));
            check($sformatf("acc_clear s%0d c%0d", s, c), 32'(bus.acc_clear), 32'(c == 2));
            check($sformatf("dout_latch s%0d c%0d", s, c), 32'(bus.dout_latch), 32'(c == HALF + 2));
            check($sformatf("busy s%0d c%0d", s, c), 32'(bus.busy), 32'(c <= HALF + 2));
            check($sformatf("overrun s%0d c%0d", s, c), 32'(bus.overrun), 32'(e_ovr));
            check($sformatf("ovr_count s%0d c%0d", s, c), 32'(bus.ovr_count), 32'(exp_ovr));
            if (s == 1 && c == 2) check("wrap_rd_k1", 32'(bus.rd_addr), 32'd127);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_wptr     = 0;
        exp_ovr      = 0;
        reset          = 1'b1;
        bus.din_enable = 1'b0;
        tick();
        tick();
        check("rst wr_en",      32'(bus.wr_en),        32'd0);
        check("rst wr_addr",    32'(bus.wr_addr),      32'd0);
        check("rst rd_addr",    32'(bus.rd_addr),      32'd0);
        check("rst coeff",      32'(bus.coeffaddress), 32'd0);
        check("rst acc_en",     32'(bus.acc_en),       32'd0);
        check("rst acc_clear",  32'(bus.acc_clear),    32'd0);
        check("rst dout_latch", 32'(bus.dout_latch),   32'd0);
        check("rst busy",       32'(bus.busy),         32'd0);
        check("rst overrun",    32'(bus.overrun),      32'd0);
        check("rst ovr_count",  32'(bus.ovr_count),    32'd0);
        reset = 1'b0;
        tick();

        // Single sample, then overrun at T+30, then drop at T+66.
        run_sample(0);
        run_sample(30);
        run_sample(66);

        // 130 back-to-back samples at period 67: wraps wr_addr through 127,0,1.
        for (int n = 0; n < 130; n++) run_sample(0);

        // Reset mid-run at T+20 with a din_enable in the reset cycle.
        bus.din_enable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.din_enable = 1'b0;
        end
        reset          = 1'b1;
        bus.din_enable = 1'b1;
        tick();
        reset          = 1'b0;
        bus.din_enable = 1'b0;
        exp_wptr       = 0;
        exp_ovr        = 0;
        check("midrst acc_en",    32'(bus.acc_en),    32'd0);
        check("midrst busy",      32'(bus.busy),      32'd0);
        check("midrst overrun",   32'(bus.overrun),   32'd0);
        check("midrst ovr_count", 32'(bus.ovr_count), 32'd0);
        check("midrst wr_en",     32'(bus.wr_en),     32'd0);
        for (int c = 22; c <= 70; c++) begin
            tick();
            check($sformatf("midrst acc_en c%0d", c),     32'(bus.acc_en),     32'd0);
            check($sformatf("midrst dout_latch c%0d", c), 32'(bus.dout_latch), 32'd0);
        end
        run_sample(0);

`ifdef SEQ_OVERRUN_CNT_EN
        // Hold din_enable high: 66 dropped samples per 67-cycle period.
        bus.din_enable = 1'b1;
        for (int c = 0; c < 67000; c++) tick();
        bus.din_enable = 1'b0;
        tick();
        tick();
        check("ovr_count saturated", 32'(bus.ovr_count), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
